decode_stage_hs: RTL and testbench
==================================

// Module: decode_stage_hs
// PURPOSE
//  Parametrised ID stage plus ID/EX pipeline register with valid/ready handshakes, replacing the keep/nop sideband pair.
//  Decodes RV32I (LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/OP-IMM/OP, optional FENCE) and reads the register file combinationally.
//  Applies N-port write-back bypass to rs1/rs2 data, inserts a load-use bubble, supports flush, and flags illegal opcodes.
//  Sits between fetch (in_*) and execute (out_*).
// PARAMETERS
//  XLEN          32  datapath width of PC, immediate and register data
//  NUM_WB        2   number of write-back bypass ports; port 0 has the highest priority
//  LOAD_USE_STALL 1  1: detect load-use and insert one bubble; 0: no detection (EX forwards)
//  FENCE_AS_NOP  1   1: opcode 0001111 decodes as a legal NOP; 0: it is illegal
// PORTS
//  clk           in   1             clock, rising edge
//  rst           in   1             synchronous reset, active-high
//  in_valid      in   1             fetch presents an instruction
//  in_ready      out  1             stage accepts in_* this cycle
//  in_pc         in   XLEN          PC of in_inst
//  in_inst       in   32            instruction word
//  rf_raddr1/2   out  5 each        in_inst[19:15] / in_inst[24:20], combinational
//  rf_rdata1/2   in   XLEN each     register-file read data, same cycle
//  wb_valid      in   NUM_WB        bypass port i write enable
//  wb_rd         in   5*NUM_WB      bypass port i destination, packed [5*i+:5]
//  wb_data       in   XLEN*NUM_WB   bypass port i data, packed [XLEN*i+:XLEN]
//  flush         in   1             kill the held and incoming instructions (taken branch or trap)
//  out_valid     out  1             ID/EX register holds an instruction
//  out_ready     in   1             EX consumes out_* this cycle
//  out_pc, out_pcp4  out  XLEN each PC and PC+4 (modulo 2^XLEN)
//  out_inst      out  32            instruction word
//  out_imm       out  XLEN          sign-extended immediate, per format
//  out_rs1_data, out_rs2_data  out  XLEN each  bypassed operand data
//  out_rs1, out_rs2, out_rd    out  5 each    register indices; out_rd=0 when the instruction has no rd
//  out_regwrite  out  1             write rd
//  out_memtoreg  out  2             write-back select: 00 ALU, 01 memory, 10 PC+4
//  out_memrw     out  2             10 load, 01 store, 00 none
//  out_branch    out  3             000 none, 001 eq, 010 ne, 011 lt, 100 ge, 101 jal, 110 jalr
//  out_br_unsigned  out  1          BLTU/BGEU compare unsigned
//  out_alu_ctrl  out  3             000 normal, 001 compare, 010 no ALU (LUI), 011 jump, 100 load, 101 store
//  out_alu_src   out  3             bit2: A=PC, bit1: A=rs1, bit0: B=rs2 (else B=imm)
//  out_alu_op    out  4             {inst[30] for OP and SRAI/SRLI, else 0, funct3}
//  out_illegal   out  1             unsupported opcode; all side-effect controls forced 0
// BEHAVIOUR
//  - Reset (rst=1 at the clock edge): every out_* register is 0 and out_valid=0. in_ready=0 while rst=1.
//  - hazard = LOAD_USE_STALL && out_valid && out_memrw==10 && out_rd!=0 && rs uses out_rd.
//    The rs-use check covers rs1 for all formats except U/J, and rs2 for OP, BRANCH and STORE.
//  - in_ready = !rst && !flush && (!out_valid || out_ready) && !hazard. Purely combinational, 0 cycles.
//  - Load (accept when in_valid && in_ready): next edge latches the decode of in_* and sets out_valid=1. Latency is 1 cycle.
//  - Bubble: if (!out_valid || out_ready) && !(in_valid && in_ready), out_valid becomes 0 next edge.
//    A hazard stall makes the load leave and a bubble enter; next cycle the consumer is accepted.
//  - Hold: if out_valid && !out_ready, all out_* keep their values.
//    Exception: out_rs1_data/out_rs2_data reload from a matching bypass port (same priority rule) so late write-backs are not lost.
//  - Bypass on load: rsN_data = wb_data[i] for the lowest i with wb_valid[i] && wb_rd[i]==rsN && rsN!=0; else rf_rdataN.
//    rsN==0 always yields 0.
//  - Flush: next edge out_valid=0. The in_* instruction is not accepted. Flush outranks hold, load and hazard; rst outranks flush.
//  - Immediates: I, S, B, U and J formats as in RV32I, sign-extended to XLEN.
//    SLLI/SRLI/SRAI use the 5-bit zero-extended shamt; inst[30] goes to out_alu_op[3].
//  - Illegal, or FENCE with FENCE_AS_NOP=0: out_valid=1, out_illegal=1, regwrite=memrw=branch=0, out_rd=0.
// TESTING
//  - Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0; after release, in_ready=1.
//  - addi x5,x0,-1 (0xFFF00293) -> next cycle out_imm=0xFFFFFFFF, out_rd=5, regwrite=1, alu_src=010, alu_op=0000.
//  - lw x6,0(x1) then add x7,x6,x2 with out_ready=1 -> in_ready=0 for 1 cycle, one bubble (out_valid=0), then add issues.
//  - wb_valid=2'b11, wb_rd={5'd3,5'd3}, wb_data={32'hB,32'hA}, instruction reads x3 -> out_rs1_data=32'hA; reading x0 -> 0.
//  - out_ready=0 for 3 cycles while wb writes x2=0x55 and held instr has rs2=x2 -> out_rs2_data=0x55, other fields unchanged.
//  - flush=1 with in_valid=1, out_valid=1 -> next cycle out_valid=0 and the instruction is not accepted;
//    bltu -> out_branch=011, out_br_unsigned=1; opcode 0x7F -> out_illegal=1, regwrite=0.

Source files
------------

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: RV32I instruction decode plus ID/EX register.
// Valid/ready handshakes, write-back bypass, load-use bubble, flush.
module decode_stage_hs #(
  parameter int XLEN           = 32,
  parameter int NUM_WB         = 2,
  parameter int LOAD_USE_STALL = 1,
  parameter int FENCE_AS_NOP   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_inst,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [XLEN-1:0]        rf_rdata1,
  input  logic [XLEN-1:0]        rf_rdata2,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [5*NUM_WB-1:0]    wb_rd,
  input  logic [XLEN*NUM_WB-1:0] wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_pcp4,
  output logic [31:0]            out_inst,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_rs1_data,
  output logic [XLEN-1:0]        out_rs2_data,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic                   out_regwrite,
  output logic [1:0]             out_memtoreg,
  output logic [1:0]             out_memrw,
  output logic [2:0]             out_branch,
  output logic                   out_br_unsigned,
  output logic [2:0]             out_alu_ctrl,
  output logic [2:0]             out_alu_src,
  output logic [3:0]             out_alu_op,
  output logic                   out_illegal
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            regwrite;
    logic [1:0]      memtoreg;
    logic [1:0]      memrw;
    logic [2:0]      branch;
    logic            br_unsigned;
    logic [2:0]      alu_ctrl;
    logic [2:0]      alu_src;
    logic [3:0]      alu_op;
    logic            illegal;
    logic            use_rs1;
    logic            use_rs2;
  } dec_t;

  dec_t        d;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm32;
  logic        is_lui;
  logic        is_auipc;
  logic        is_jal;
  logic        is_jalr;
  logic        is_br;
  logic        is_ld;
  logic        is_st;
  logic        is_imm;
  logic        is_op;
  logic        is_fnop;
  logic        is_shift;
  logic        hazard;
  logic        accept;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign rd  = in_inst[11:7];

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  assign is_lui   = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;
  assign is_jal   = opc == OP_JAL;
  assign is_jalr  = opc == OP_JALR;
  assign is_br    = opc == OP_BR;
  assign is_ld    = opc == OP_LD;
  assign is_st    = opc == OP_ST;
  assign is_imm   = opc == OP_IMM;
  assign is_op    = opc == OP_OP;
  assign is_fnop  = (opc == OP_FENCE) && (FENCE_AS_NOP != 0);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Raw 32-bit immediates for each instruction format.
  always_comb begin
    imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
             in_inst[30:25], in_inst[11:8], 1'b0};
    imm_u = {in_inst[31:12], 12'b0};
    imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
             in_inst[20], in_inst[30:21], 1'b0};
  end

  // Main decoder; illegal encodings clear every control.
  always_comb begin
    d         = '0;
    imm32     = '0;
    d.rd      = rd;
    d.use_rs1 = 1'b1;
    unique case (1'b1)
      is_lui: begin
        imm32      = imm_u;
        d.regwrite = 1'b1;
        d.alu_ctrl = 3'b010;
        d.use_rs1  = 1'b0;
      end
      is_auipc: begin
        imm32      = imm_u;
        d.regwrite = 1'b1;
        d.alu_src  = 3'b100;
        d.use_rs1  = 1'b0;
      end
      is_jal: begin
        imm32      = imm_j;
        d.regwrite = 1'b1;
        d.memtoreg = 2'b10;
        d.branch   = 3'b101;
        d.alu_ctrl = 3'b011;
        d.alu_src  = 3'b100;
        d.use_rs1  = 1'b0;
      end
      is_jalr: begin
        imm32      = imm_i;
        d.regwrite = 1'b1;
        d.memtoreg = 2'b10;
        d.branch   = 3'b110;
        d.alu_ctrl = 3'b011;
        d.alu_src  = 3'b010;
        d.alu_op   = {1'b0, f3};
      end
      is_br: begin
        imm32      = imm_b;
        d.rd       = '0;
        d.alu_ctrl = 3'b001;
        d.alu_src  = 3'b011;
        d.alu_op   = {1'b0, f3};
        d.use_rs2  = 1'b1;
        unique case (f3)
          3'b000:  d.branch = 3'b001;
          3'b001:  d.branch = 3'b010;
          3'b100:  d.branch = 3'b011;
          3'b101:  d.branch = 3'b100;
          3'b110: begin
            d.branch      = 3'b011;
            d.br_unsigned = 1'b1;
          end
          3'b111: begin
            d.branch      = 3'b100;
            d.br_unsigned = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      is_ld: begin
        imm32      = imm_i;
        d.regwrite = 1'b1;
        d.memtoreg = 2'b01;
        d.memrw    = 2'b10;
        d.alu_ctrl = 3'b100;
        d.alu_src  = 3'b010;
        d.alu_op   = {1'b0, f3};
      end
      is_st: begin
        imm32      = imm_s;
        d.rd       = '0;
        d.memrw    = 2'b01;
        d.alu_ctrl = 3'b101;
        d.alu_src  = 3'b010;
        d.alu_op   = {1'b0, f3};
        d.use_rs2  = 1'b1;
      end
      is_imm: begin
        imm32      = is_shift ? {27'b0, in_inst[24:20]} : imm_i;
        d.regwrite = 1'b1;
        d.alu_src  = 3'b010;
        d.alu_op   = {(f3 == 3'b101) & in_inst[30], f3};
      end
      is_op: begin
        d.regwrite = 1'b1;
        d.alu_src  = 3'b011;
        d.alu_op   = {in_inst[30], f3};
        d.use_rs2  = 1'b1;
      end
      is_fnop: begin
        d.rd = '0;
      end
      default: d.illegal = 1'b1;
    endcase
    d.imm = XLEN'($signed(imm32));
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
  end

  // Youngest-port-last scan so the lowest matching port wins.
  function automatic logic [XLEN-1:0] byp(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] dflt
  );
    logic [XLEN-1:0] r;
    r = dflt;
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (wb_valid[i] && (wb_rd[5*i +: 5] == rs))
        r = wb_data[XLEN*i +: XLEN];
    end
    if (rs == 5'd0)
      r = '0;
    return r;
  endfunction

  // Stall the consumer of a load sitting in ID/EX.
  always_comb begin
    hazard = (LOAD_USE_STALL != 0) && out_valid &&
             (out_memrw == 2'b10) && (out_rd != 5'd0) &&
             ((d.use_rs1 && (rs1 == out_rd)) ||
              (d.use_rs2 && (rs2 == out_rd)));
    in_ready = !rst && !flush && (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  // ID/EX register: flush, then hold, then load, else bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_pcp4        <= '0;
      out_inst        <= '0;
      out_imm         <= '0;
      out_rs1_data    <= '0;
      out_rs2_data    <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_rd          <= '0;
      out_regwrite    <= 1'b0;
      out_memtoreg    <= '0;
      out_memrw       <= '0;
      out_branch      <= '0;
      out_br_unsigned <= 1'b0;
      out_alu_ctrl    <= '0;
      out_alu_src     <= '0;
      out_alu_op      <= '0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_valid && !out_ready) begin
      out_rs1_data <= byp(out_rs1, out_rs1_data);
      out_rs2_data <= byp(out_rs2, out_rs2_data);
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_pc          <= in_pc;
      out_pcp4        <= in_pc + XLEN'(4);
      out_inst        <= in_inst;
      out_imm         <= d.imm;
      out_rs1_data    <= byp(rs1, rf_rdata1);
      out_rs2_data    <= byp(rs2, rf_rdata2);
      out_rs1         <= rs1;
      out_rs2         <= rs2;
      out_rd          <= d.rd;
      out_regwrite    <= d.regwrite;
      out_memtoreg    <= d.memtoreg;
      out_memrw       <= d.memrw;
      out_branch      <= d.branch;
      out_br_unsigned <= d.br_unsigned;
      out_alu_ctrl    <= d.alu_ctrl;
      out_alu_src     <= d.alu_src;
      out_alu_op      <= d.alu_op;
      out_illegal     <= d.illegal;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs: scoreboard bench for decode_stage_hs.
// Directed vectors push expectations; a monitor checks each issue.
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcp4;
  logic [31:0] out_inst;
  logic [31:0] out_imm;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic [1:0]  out_memtoreg;
  logic [1:0]  out_memrw;
  logic [2:0]  out_branch;
  logic        out_br_unsigned;
  logic [2:0]  out_alu_ctrl;
  logic [2:0]  out_alu_src;
  logic [3:0]  out_alu_op;
  logic        out_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic [19:0] ctrl;
    logic [2:0]  chk;
  } exp_t;

  exp_t q[$];

  decode_stage_hs dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcp4(out_pcp4), .out_inst(out_inst),
    .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
    .out_memrw(out_memrw), .out_branch(out_branch),
    .out_br_unsigned(out_br_unsigned),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src),
    .out_alu_op(out_alu_op), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Register file returns a tag of the index, even for x0.
  assign rf_rdata1 = 32'hCAFE_0000 | {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'hCAFE_0000 | {27'd0, rf_raddr2};

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ctl(
    input logic       rw, input logic [1:0] mt,
    input logic [1:0] mrw, input logic [2:0] br,
    input logic       bru, input logic [2:0] ac,
    input logic [2:0] as, input logic [3:0] aop,
    input logic       ill);
    return {rw, mt, mrw, br, bru, ac, as, aop, ill};
  endfunction

  function automatic exp_t mk(
    input logic [31:0] pc, input logic [31:0] inst,
    input logic [31:0] imm, input logic [31:0] rs1d,
    input logic [31:0] rs2d, input logic [4:0] rd,
    input logic [19:0] ctrl, input logic [2:0] chk);
    exp_t e;
    e.pc = pc; e.inst = inst; e.imm = imm;
    e.rs1d = rs1d; e.rs2d = rs2d; e.rd = rd;
    e.ctrl = ctrl; e.chk = chk;
    return e;
  endfunction

  // Monitor: every consumed instruction is compared to the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_issue", out_pc, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pc", out_pc, e.pc);
        check("pcp4", out_pcp4, e.pc + 32'd4);
        check("inst", out_inst, e.inst);
        check("rd", {27'd0, out_rd}, {27'd0, e.rd});
        check("ctrl",
              {12'd0, out_regwrite, out_memtoreg, out_memrw, out_branch,
               out_br_unsigned, out_alu_ctrl, out_alu_src, out_alu_op,
               out_illegal},
              {12'd0, e.ctrl});
        if (e.chk[0]) check("imm", out_imm, e.imm);
        if (e.chk[1]) check("rs1_data", out_rs1_data, e.rs1d);
        if (e.chk[2]) check("rs2_data", out_rs2_data, e.rs2d);
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                       input bit push, input exp_t e);
    in_pc    = pc;
    in_inst  = inst;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready && push) q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  exp_t none;

  initial begin
    none      = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h40;
    in_inst   = 32'hFFF0_0293;
    wb_valid  = '0;
    wb_rd     = '0;
    wb_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset with a pending instruction.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_ctrl",
          {12'd0, out_regwrite, out_memtoreg, out_memrw, out_branch,
           out_br_unsigned, out_alu_ctrl, out_alu_src, out_alu_op,
           out_illegal, out_rd}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // addi x5,x0,-1
    issue(32'h100, 32'hFFF0_0293, 1,
          mk(32'h100, 32'hFFF0_0293, 32'hFFFF_FFFF, 32'd0, 0, 5'd5,
             ctl(1, 2'b00, 2'b00, 3'b000, 0, 3'b000, 3'b010, 4'b0000, 0),
             3'b011));

    // lw x6,0(x1) followed by dependent add x7,x6,x2
    issue(32'h104, 32'h0000_A303, 1,
          mk(32'h104, 32'h0000_A303, 32'd0, 32'hCAFE_0001, 0, 5'd6,
             ctl(1, 2'b01, 2'b10, 3'b000, 0, 3'b100, 3'b010, 4'b0010, 0),
             3'b011));
    in_pc    = 32'h108;
    in_inst  = 32'h0023_03B3;
    in_valid = 1'b1;
    @(negedge clk);
    check("hazard_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bubble_out_valid", {31'd0, out_valid}, 32'd0);
    check("bubble_in_ready", {31'd0, in_ready}, 32'd1);
    q.push_back(mk(32'h108, 32'h0023_03B3, 0, 32'hCAFE_0006,
                   32'hCAFE_0002, 5'd7,
                   ctl(1, 2'b00, 2'b00, 3'b000, 0, 3'b000, 3'b011,
                       4'b0000, 0), 3'b110));
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Bypass priority: both ports write x3, port 0 wins
    wb_valid = 2'b11;
    wb_rd    = {5'd3, 5'd3};
    wb_data  = {32'hB, 32'hA};
    issue(32'h10C, 32'h0001_8433, 1,
          mk(32'h10C, 32'h0001_8433, 0, 32'hA, 32'd0, 5'd8,
             ctl(1, 2'b00, 2'b00, 3'b000, 0, 3'b000, 3'b011, 4'b0000, 0),
             3'b110));
    // x0 never bypasses, even when a port names it
    wb_rd = {5'd3, 5'd0};
    issue(32'h110, 32'h0030_04B3, 1,
          mk(32'h110, 32'h0030_04B3, 0, 32'd0, 32'hB, 5'd9,
             ctl(1, 2'b00, 2'b00, 3'b000, 0, 3'b000, 3'b011, 4'b0000, 0),
             3'b110));
    wb_valid = '0;
    @(posedge clk);
    #1;

    // Hold sw x2,4(x1) while a late write-back of x2 arrives
    out_ready = 1'b0;
    issue(32'h114, 32'h0020_A223, 1,
          mk(32'h114, 32'h0020_A223, 32'd4, 32'hCAFE_0001, 32'h55, 5'd0,
             ctl(0, 2'b00, 2'b01, 3'b000, 0, 3'b101, 3'b010, 4'b0010, 0),
             3'b111));
    wb_valid = 2'b01;
    wb_rd    = {5'd0, 5'd2};
    wb_data  = {32'h0, 32'h55};
    @(negedge clk);
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    wb_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_rs2_data", out_rs2_data, 32'h55);
    check("hold_out_imm", out_imm, 32'd4);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Flush kills the held instruction and the incoming one
    out_ready = 1'b0;
    issue(32'h300, 32'hFFF0_0293, 0, none);
    in_pc    = 32'h304;
    in_inst  = 32'h0023_03B3;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("flush_not_accepted", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // bltu x1,x2,+8
    issue(32'h118, 32'h0020_E463, 1,
          mk(32'h118, 32'h0020_E463, 32'd8, 32'hCAFE_0001, 32'hCAFE_0002,
             5'd0,
             ctl(0, 2'b00, 2'b00, 3'b011, 1, 3'b001, 3'b011, 4'b0110, 0),
             3'b111));
    // opcode 0x7F with rd field 6
    issue(32'h11C, 32'h0000_037F, 1,
          mk(32'h11C, 32'h0000_037F, 0, 0, 0, 5'd0,
             ctl(0, 2'b00, 2'b00, 3'b000, 0, 3'b000, 3'b000, 4'b0000, 1),
             3'b000));
    // srai x10,x1,3
    issue(32'h120, 32'h4030_D513, 1,
          mk(32'h120, 32'h4030_D513, 32'd3, 32'hCAFE_0001, 0, 5'd10,
             ctl(1, 2'b00, 2'b00, 3'b000, 0, 3'b000, 3'b010, 4'b1101, 0),
             3'b011));
    // lui x11,0x12345 at the top of the address space
    issue(32'hFFFF_FFFC, 32'h1234_55B7, 1,
          mk(32'hFFFF_FFFC, 32'h1234_55B7, 32'h1234_5000, 0, 0, 5'd11,
             ctl(1, 2'b00, 2'b00, 3'b000, 0, 3'b010, 3'b000, 4'b0000, 0),
             3'b001));
    // jal x1,-4
    issue(32'h200, 32'hFFDF_F0EF, 1,
          mk(32'h200, 32'hFFDF_F0EF, 32'hFFFF_FFFC, 0, 0, 5'd1,
             ctl(1, 2'b10, 2'b00, 3'b101, 0, 3'b011, 3'b100, 4'b0000, 0),
             3'b001));
    // fence decodes as a legal NOP
    issue(32'h204, 32'h0FF0_000F, 1,
          mk(32'h204, 32'h0FF0_000F, 0, 0, 0, 5'd0,
             ctl(0, 2'b00, 2'b00, 3'b000, 0, 3'b000, 3'b000, 4'b0000, 0),
             3'b000));

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
